// File: rtl/cruise_controller_if.sv
// Bundles the cruise controller's driver-side commands, datapath feedback and controller outputs.
// The controller uses the slave modport; the driver/datapath side uses master.
interface cruise_controller_if;
    logic       on_off;
    logic       set_btn;
    logic       resume_btn;
    logic       inc_btn;
    logic       dec_btn;
    logic       brake;
    logic       cancel;
    logic [7:0] vfeli;
    logic       gt;
    logic       eq;
    logic       lt;
    logic [7:0] vout;
    logic [1:0] s;
    logic [7:0] vmatloob;
    logic       engaged;
    logic       throttle_up;
    logic       throttle_down;

    modport master (
        output on_off, set_btn, resume_btn, inc_btn, dec_btn, brake, cancel,
        output vfeli, gt, eq, lt, vout,
        input  s, vmatloob, engaged, throttle_up, throttle_down
    );

    modport slave (
        input  on_off, set_btn, resume_btn, inc_btn, dec_btn, brake, cancel,
        input  vfeli, gt, eq, lt, vout,
        output s, vmatloob, engaged, throttle_up, throttle_down
    );
endinterface

// File: rtl/cruise_controller.sv
// Cruise control sequencer: holds the target speed, drives the external compare/step
// datapath through opcode s, and turns compare results into registered throttle requests.
module cruise_controller #(
    parameter logic [7:0] VMIN = 8'd30,
    parameter logic [7:0] VMAX = 8'd200
) (
    input  logic                clock,
    input  logic                reset,
    cruise_controller_if.slave  bus
);

    typedef enum logic [2:0] {
        OFF, IDLE, CMP, EVAL, INC, INC_WAIT, DEC, DEC_WAIT
    } state_t;

    state_t     state_reg, state_next;
    logic [1:0] s_reg, s_next;
    logic [7:0] vmatloob_reg, vmatloob_next;
    logic       engaged_reg, engaged_next;
    logic       throttle_up_reg, throttle_up_next;
    logic       throttle_down_reg, throttle_down_next;
    logic       valid_reg, valid_next;
    logic       pend_inc_reg, pend_inc_next;
    logic       pend_dec_reg, pend_dec_next;
    logic       in_range;

    assign in_range = (bus.vfeli >= VMIN) && (bus.vfeli <= VMAX);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg         <= OFF;
            s_reg             <= 2'b00;
            vmatloob_reg      <= 8'd0;
            engaged_reg       <= 1'b0;
            throttle_up_reg   <= 1'b0;
            throttle_down_reg <= 1'b0;
            valid_reg         <= 1'b0;
            pend_inc_reg      <= 1'b0;
            pend_dec_reg      <= 1'b0;
        end else begin
            state_reg         <= state_next;
            s_reg             <= s_next;
            vmatloob_reg      <= vmatloob_next;
            engaged_reg       <= engaged_next;
            throttle_up_reg   <= throttle_up_next;
            throttle_down_reg <= throttle_down_next;
            valid_reg         <= valid_next;
            pend_inc_reg      <= pend_inc_next;
            pend_dec_reg      <= pend_dec_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        vmatloob_next      = vmatloob_reg;
        valid_next         = valid_reg;
        pend_inc_next      = pend_inc_reg;
        pend_dec_next      = pend_dec_reg;
        throttle_up_next   = throttle_up_reg;
        throttle_down_next = throttle_down_reg;
        s_next             = 2'b00;
        engaged_next       = 1'b0;

        if (!bus.on_off) begin
            state_next = OFF;
        end else if (engaged_reg && (bus.brake || bus.cancel)) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                OFF:  state_next = IDLE;
                IDLE: begin
                    if (bus.set_btn && in_range) begin
                        vmatloob_next = bus.vfeli;
                        valid_next    = 1'b1;
                        state_next    = CMP;
                    end else if (bus.resume_btn && valid_reg) begin
                        state_next    = CMP;
                    end
                end
                CMP:  state_next = EVAL;
                EVAL: begin
                    // Compare flags were registered by the datapath during CMP.
                    throttle_up_next   = bus.lt && !bus.eq;
                    throttle_down_next = bus.gt && !bus.eq;
                    state_next         = CMP;
                    if (pend_inc_reg && pend_dec_reg) begin
                        pend_inc_next = 1'b0;
                        pend_dec_next = 1'b0;
                    end else if (pend_inc_reg) begin
                        if (vmatloob_reg >= VMAX) pend_inc_next = 1'b0;
                        else                      state_next    = INC;
                    end else if (pend_dec_reg) begin
                        if (vmatloob_reg <= VMIN) pend_dec_next = 1'b0;
                        else                      state_next    = DEC;
                    end
                end
                INC:  state_next = INC_WAIT;
                DEC:  state_next = DEC_WAIT;
                INC_WAIT: begin
                    vmatloob_next = bus.vout;
                    pend_inc_next = 1'b0;
                    state_next    = CMP;
                end
                DEC_WAIT: begin
                    vmatloob_next = bus.vout;
                    pend_dec_next = 1'b0;
                    state_next    = CMP;
                end
                default: state_next = OFF;
            endcase
        end

        // New button pulses are ORed in after servicing so a press during a step is not lost.
        if (engaged_reg) begin
            pend_inc_next = pend_inc_next || bus.inc_btn;
            pend_dec_next = pend_dec_next || bus.dec_btn;
        end

        if (state_next == OFF || state_next == IDLE) begin
            pend_inc_next      = 1'b0;
            pend_dec_next      = 1'b0;
            throttle_up_next   = 1'b0;
            throttle_down_next = 1'b0;
        end
        if (state_next == OFF) begin
            valid_next = 1'b0;
        end

        case (state_next)
            CMP:     s_next = 2'b01;
            INC:     s_next = 2'b10;
            DEC:     s_next = 2'b11;
            default: s_next = 2'b00;
        endcase
        engaged_next = (state_next != OFF) && (state_next != IDLE);
    end

    assign bus.s             = s_reg;
    assign bus.vmatloob      = vmatloob_reg;
    assign bus.engaged       = engaged_reg;
    assign bus.throttle_up   = throttle_up_reg;
    assign bus.throttle_down = throttle_down_reg;

endmodule
